// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: special digit codes,
// the active-low glyph table (bit 6 = g ... bit 0 = a) and the simulation slot length.
package sevenseg_pkg;

   localparam logic [4:0] CODE_BLANK = 5'h10;
   localparam logic [4:0] CODE_MINUS = 5'h11;
   localparam logic [4:0] CODE_UNDER = 5'h12;

   localparam int SIM_SLOT_LEN = 4;

   localparam logic [6:0] SEG_OFF   = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_UNDER = 7'h77;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational glyph decoder: 5-bit digit code to active-low segments g..a.
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_OFF;
      if (!code[4]) begin
         seg_n = hex_glyph(code[3:0]);
      end else begin
         case (code)
            CODE_BLANK: seg_n = SEG_OFF;
            CODE_MINUS: seg_n = SEG_MINUS;
            CODE_UNDER: seg_n = SEG_UNDER;
            default:    seg_n = SEG_OFF;
         endcase
      end
   end

endmodule

// File: rtl/sevenseg_mux.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering and PWM dimming.
// Optional leading-zero suppression is compiled in with `define SEVENSEG_LZS_EN.
module sevenseg_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int BRIGHT_W    = 4,
   parameter int SIMULATE    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [5*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    load,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int SLOT_LEN = (SIMULATE != 0) ? SIM_SLOT_LEN : REFRESH_DIV;
   localparam int PRESC_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam int IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SLOT_LEN - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [PRESC_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
   logic                    pend_q, pend_d;
   logic [5*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    wrap, pwm_on, lit;
   logic [NUM_DIGITS-1:0]   sup;
   logic [4:0]              cur_code;
   logic                    cur_dp, cur_blank, cur_sup;
   logic [6:0]              dec_seg;

   assign wrap = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);

   always_comb begin
      presc_d = presc_q + PRESC_W'(1);
      idx_d   = idx_q;
      pwm_d   = pwm_q + BRIGHT_W'(1);
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // New data only reaches the active set on the frame wrap, so a frame never tears.
   always_comb begin
      act_dig_d    = act_dig_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      pend_dig_d   = pend_dig_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_d       = pend_q;
      if (wrap) begin
         pend_d = 1'b0;
         if (load) begin
            act_dig_d   = digits;
            act_dp_d    = dp_in;
            act_blank_d = blank;
         end else if (pend_q) begin
            act_dig_d   = pend_dig_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
         end
      end else if (load) begin
         pend_dig_d   = digits;
         pend_dp_d    = dp_in;
         pend_blank_d = blank;
         pend_d       = 1'b1;
      end
   end

`ifdef SEVENSEG_LZS_EN
   logic run;
   always_comb begin
      sup = '0;
      run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         if (act_dig_q[5*i +: 5] != 5'd0) run = 1'b0;
         sup[i] = run;
      end
   end
`else
   assign sup = '0;
`endif

   always_comb begin
      cur_code  = 5'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      cur_sup   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_code  = act_dig_q[5*i +: 5];
            cur_dp    = act_dp_q[i];
            cur_blank = act_blank_q[i];
            cur_sup   = sup[i];
         end
      end
   end

   sevenseg_decode u_decode (
      .code  (cur_code),
      .seg_n (dec_seg)
   );

   // Slot clock 0 keeps every anode off so the previous glyph cannot ghost onto the next digit.
   always_comb begin
      pwm_on = (brightness == {BRIGHT_W{1'b1}}) || (pwm_q < brightness);
      lit    = (presc_q != '0) && pwm_on;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_d[i] = !(lit && (idx_q == IDX_W'(i)));
      end
      seg_d        = (cur_blank || cur_sup) ? SEG_OFF : dec_seg;
      dp_d         = cur_blank ? 1'b1 : ~cur_dp;
      frame_tick_d = wrap;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         pend_q       <= 1'b0;
         act_dig_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '1;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '1;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         pend_q       <= pend_d;
         act_dig_q    <= act_dig_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         pend_dig_q   <= pend_dig_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/sevenseg_mux.md
SEVENSEG_MUX -- requirements
Module: sevenseg_mux

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning number of multiplexed digits (2..16).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clocks per digit slot.
REQ-003 The block SHALL have parameter BRIGHT_W, default 4, meaning brightness control width.
REQ-004 The block SHALL have parameter SIMULATE, default 0, meaning that 1 forces the slot length to 4 clocks.
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; one clock only.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port digits, input, 5*NUM_DIGITS bits: 5-bit code per digit; digit i at [5i+4:5i].
REQ-008 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal point per digit, 1=lit.
REQ-009 The block SHALL have port blank, input, NUM_DIGITS bits: per-digit blank, 1=dark.
REQ-010 The block SHALL have port load, input, 1 bit: strobe that captures digits/dp_in/blank.
REQ-011 The block SHALL have port brightness, input, BRIGHT_W bits: PWM duty.
REQ-012 The block SHALL have port seg, output, 7 bits: segments g..a, active-low.
REQ-013 The block SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-014 The block SHALL have port an, output, NUM_DIGITS bits: anodes, active-low, one-hot-or-none.
REQ-015 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at frame wrap.

Function
REQ-016 Slot length SHALL be L = (SIMULATE ? 4 : REFRESH_DIV); the prescaler counts 0..L-1 and wraps.
REQ-017 At prescaler terminal count, the digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-018 frame_tick SHALL be high for exactly the one cycle in which the index wraps to 0.
REQ-019 A load pulse SHALL copy the inputs into a pending shadow and set a pending flag; a later load before transfer overwrites the shadow.
REQ-020 The pending shadow SHALL transfer to the active registers on the frame-wrap cycle only, clearing the pending flag (no mid-frame tearing).
REQ-021 load coincident with frame wrap SHALL transfer that cycle's input values directly to active, with the pending flag left clear.
REQ-022 Decode SHALL map codes 0x00-0x0F to hex glyphs 0-F, 0x11 to minus (g only), 0x12 to underscore (d only), and all other codes to blank.
REQ-023 A BRIGHT_W-bit PWM counter SHALL increment every clock and wrap.
REQ-024 The current anode SHALL be driven low only while pwm_cnt < brightness, or always when brightness is all ones; brightness 0 SHALL give all anodes high.
REQ-025 Any digit with active blank=1 SHALL drive seg=7'h7F and dp=1 while its anode timing is unchanged.
REQ-026 seg, dp and an SHALL be registered; they reflect the new index one clock after the index changes.
REQ-027 Anodes SHALL be all high for the first clock of every slot (ghosting guard).

Reset
REQ-028 Reset SHALL asynchronously set an to all ones, seg to 7'h7F, dp to 1 and frame_tick to 0.
REQ-029 Reset SHALL clear the prescaler, the index, pwm_cnt and the pending flag.
REQ-030 Reset SHALL clear the active/pending digits and dp, and set the active/pending blank to all ones.
REQ-031 Reset asserted mid-slot or mid-pending SHALL discard pending data; scanning restarts at digit 0 after release.

Configuration
REQ-032 With SEVENSEG_LZS_EN defined, active digits with code 0x00 SHALL be blanked from the highest index downward until the first nonzero or unblanked digit; digit 0 is never suppressed and dp remains lit if set.
REQ-033 Without SEVENSEG_LZS_EN, no suppression SHALL occur and code 0x00 shows "0".

Structure
REQ-034 Code constants (CODE_BLANK=0x10, CODE_MINUS=0x11, CODE_UNDER=0x12), the segment glyph table and the SIMULATE slot length SHALL reside in shared package sevenseg_pkg.
REQ-035 Glyph decoding SHALL be a combinational sub-module sevenseg_decode (5-bit code in, 7-bit active-low seg out).

Verification (NUM_DIGITS=4, SIMULATE=1, BRIGHT_W=4)
REQ-036 Bench SHALL check: reset held 3 clocks -> an=4'hF, seg=7'h7F, dp=1; after release and before any load, all digits stay dark.
REQ-037 Bench SHALL check: load digits={0x3,0x2,0x1,0x0}, blank=0, brightness=4'hF -> after next frame_tick, an cycles E,D,B,7 with 4-clock slots (first clock of each slot F) and seg shows 0,1,2,3.
REQ-038 Bench SHALL check: load 0x5 mid-frame, then load 0xA before wrap -> the frame in progress is unchanged; 0xA appears after wrap and 0x5 is never displayed.
REQ-039 Bench SHALL check: brightness=4'h4 -> an low for 4 of every 16 clocks in the active slot region; brightness=0 -> an stays 4'hF.
REQ-040 Bench SHALL check: load asserted exactly on the frame-wrap cycle -> new values are displayed in the immediately following frame.
REQ-041 Bench SHALL check: with SEVENSEG_LZS_EN, digits={0x0,0x0,0x7,0x0} -> digits 3 and 2 are dark, and digit 1 shows 7 and digit 0 shows 0; without SEVENSEG_LZS_EN -> the display shows 0070.
